// File: rtl/imem_read_arbiter_if.sv
// Memory-side read bus of the instruction block memory: hold-enable request with ready/data return.
interface imem_read_arbiter_if #(
  parameter int ADDR_W  = 10,
  parameter int BLOCK_W = 128
) ();
  logic               mem_ren;
  logic [ADDR_W-1:0]  mem_addr;
  logic               mem_ready;
  logic [BLOCK_W-1:0] mem_dout;

  modport master (
    output mem_ren,
    output mem_addr,
    input  mem_ready,
    input  mem_dout
  );

  modport slave (
    input  mem_ren,
    input  mem_addr,
    output mem_ready,
    output mem_dout
  );
endinterface

// File: rtl/imem_read_arbiter.sv
// Shares the instruction memory read port between demand refill and prefetch; demand wins and may pre-empt.
// done/drop pulse one cycle after mem_ready/abort; requesters hold req until served, then see a one-cycle gap.
module imem_read_arbiter #(
  parameter int ADDR_W  = 10,
  parameter int BLOCK_W = 128,
  parameter int TIMEOUT = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dem_req,
  input  logic [ADDR_W-1:0]    dem_addr,
  output logic                 dem_done,
  input  logic                 pf_req,
  input  logic [ADDR_W-1:0]    pf_addr,
  output logic                 pf_done,
  output logic                 pf_drop,
  output logic [BLOCK_W-1:0]   rdata,
  output logic                 err,
  imem_read_arbiter_if.master  mem
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_DEM = 1'b0,
    OWN_PF  = 1'b1
  } owner_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t               state_q;
  owner_t               owner_q;
  logic                 merged_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [7:0]           cnt_q;
  logic [BLOCK_W-1:0]   rdata_q;
  logic                 err_q;
  logic                 dem_done_q;
  logic                 pf_done_q;
  logic                 pf_drop_q;

  logic [7:0]           cnt_d;
  logic                 dem_hit;
  logic                 pf_preempt;
  logic                 pf_abort;
  logic                 pf_merge;
  logic                 timeout_hit;
  logic                 finish_merged;

  // A demand arriving during a prefetch read either joins it (same block) or kills it.
  always_comb begin
    cnt_d         = cnt_q + 8'd1;
    dem_hit       = (dem_addr == addr_q);
    pf_preempt    = (owner_q == OWN_PF) && dem_req && !mem.mem_ready;
    pf_abort      = pf_preempt && !dem_hit;
    pf_merge      = pf_preempt && dem_hit;
    timeout_hit   = (cnt_d == TMO);
    finish_merged = merged_q || pf_merge;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_DEM;
      merged_q   <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      dem_done_q <= 1'b0;
      pf_done_q  <= 1'b0;
      pf_drop_q  <= 1'b0;
    end else begin
      dem_done_q <= 1'b0;
      pf_done_q  <= 1'b0;
      pf_drop_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (dem_req) begin
            addr_q   <= dem_addr;
            owner_q  <= OWN_DEM;
            merged_q <= pf_req && (pf_addr == dem_addr);
            state_q  <= S_READ;
          end else if (pf_req) begin
            addr_q   <= pf_addr;
            owner_q  <= OWN_PF;
            merged_q <= 1'b0;
            state_q  <= S_READ;
          end
        end
        S_READ: begin
          cnt_q <= cnt_d;
          if (mem.mem_ready) begin
            rdata_q    <= mem.mem_dout;
            dem_done_q <= (owner_q == OWN_DEM) || merged_q;
            pf_done_q  <= (owner_q == OWN_PF) || merged_q;
            state_q    <= S_GAP;
          end else if (pf_abort) begin
            pf_drop_q <= 1'b1;
            state_q   <= S_GAP;
          end else begin
            if (pf_merge) begin
              merged_q <= 1'b1;
            end
            // A timed-out read still completes so neither requester waits forever.
            if (timeout_hit) begin
              err_q      <= 1'b1;
              rdata_q    <= '0;
              dem_done_q <= (owner_q == OWN_DEM) || finish_merged;
              pf_done_q  <= (owner_q == OWN_PF) || finish_merged;
              state_q    <= S_GAP;
            end
          end
        end
        S_GAP: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign mem.mem_ren  = (state_q == S_READ);
  assign mem.mem_addr = addr_q;

  assign dem_done = dem_done_q;
  assign pf_done  = pf_done_q;
  assign pf_drop  = pf_drop_q;
  assign rdata    = rdata_q;
  assign err      = err_q;

endmodule

// File: tb/tb_imem_read_arbiter.sv
// Directed bench for imem_read_arbiter: event scoreboard checked every cycle plus hand-computed pins.
module tb_imem_read_arbiter;
  localparam int AW  = 10;
  localparam int BW  = 128;
  localparam int TMO = 8;

  logic          clk;
  logic          rst_n;
  logic          dem_req;
  logic          pf_req;
  logic          dem_done;
  logic          pf_done;
  logic          pf_drop;
  logic          err;
  logic          never_ready;
  logic [AW-1:0] dem_addr;
  logic [AW-1:0] pf_addr;
  logic [BW-1:0] rdata;
  logic [7:0]    mcnt;
  int            checks;
  int            errors;

  typedef struct {
    logic          dem;
    logic          pf;
    logic          drop;
    logic [AW-1:0] addr;
    logic [BW-1:0] rdata;
    logic          err;
    int            len;
  } ev_t;

  ev_t           evq[$];
  logic [BW-1:0] exp_rdata;
  logic          exp_err;

  imem_read_arbiter_if #(.ADDR_W(AW), .BLOCK_W(BW)) mem_if ();

  imem_read_arbiter #(.ADDR_W(AW), .BLOCK_W(BW), .TIMEOUT(TMO)) dut (
    .clock    (clk),
    .reset    (rst_n),
    .dem_req  (dem_req),
    .dem_addr (dem_addr),
    .dem_done (dem_done),
    .pf_req   (pf_req),
    .pf_addr  (pf_addr),
    .pf_done  (pf_done),
    .pf_drop  (pf_drop),
    .rdata    (rdata),
    .err      (err),
    .mem      (mem_if)
  );

  function automatic logic [BW-1:0] blk(input logic [AW-1:0] a);
    logic [15:0] w;
    w = 16'h5400 | {6'd0, a};
    return {8{w}};
  endfunction

  function automatic ev_t mk(input logic d, input logic p, input logic dr, input logic [AW-1:0] a,
                             input logic [BW-1:0] rd, input logic e, input int len);
    ev_t ev;
    ev.dem = d; ev.pf = p; ev.drop = dr; ev.addr = a; ev.rdata = rd; ev.err = e; ev.len = len;
    return ev;
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory: ready on the third consecutive cycle of mem_ren, unless held off entirely.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mcnt <= 8'd0;
    else if (mem_if.mem_ren) mcnt <= mcnt + 8'd1;
    else mcnt <= 8'd0;
  end
  assign mem_if.mem_ready = mem_if.mem_ren && !never_ready && (mcnt == 8'd2);
  assign mem_if.mem_dout  = mem_if.mem_ready ? blk(mem_if.mem_addr) : ~blk(mem_if.mem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : compare
    logic prev_ren;
    logic prev_ready;
    logic pulse;
    int   run_len;
    int   low_len;
    ev_t  ev;
    prev_ren = 1'b0; prev_ready = 1'b0; run_len = 0; low_len = 2;
    exp_rdata = '0; exp_err = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        evq.delete();
        exp_rdata = '0; exp_err = 1'b0;
        prev_ren = 1'b0; prev_ready = 1'b0; run_len = 0; low_len = 2;
      end else begin
        pulse = dem_done | pf_done | pf_drop;
        if (prev_ren && prev_ready) chk("done_after_ready", BW'(pulse), BW'(1));
        if (pulse) begin
          chk("pulse_after_read", BW'({prev_ren, mem_if.mem_ren}), BW'(2'b10));
          chk("pulse_expected", BW'(evq.size() != 0), BW'(1));
          if (evq.size() != 0) begin
            ev = evq.pop_front();
            chk("pulse_kind", BW'({dem_done, pf_done, pf_drop}), BW'({ev.dem, ev.pf, ev.drop}));
            chk("read_cycles", BW'(run_len), BW'(ev.len));
            if (!ev.drop) exp_rdata = ev.rdata;
            exp_err = exp_err | ev.err;
          end
        end
        if (mem_if.mem_ren && !prev_ren) begin
          chk("ren_spacing", BW'(low_len >= 2), BW'(1));
          chk("read_expected", BW'(evq.size() != 0), BW'(1));
          if (evq.size() != 0) chk("read_addr", BW'(mem_if.mem_addr), BW'(evq[0].addr));
        end
        chk("rdata", rdata, exp_rdata);
        chk("err", BW'(err), BW'(exp_err));
        if (mem_if.mem_ren) begin
          run_len = prev_ren ? run_len + 1 : 1;
          low_len = 0;
        end else begin
          low_len++;
        end
        prev_ren   = mem_if.mem_ren;
        prev_ready = mem_if.mem_ready;
      end
    end
  end

  // Waits for the next done/drop pulse and releases the served requester(s), as a requester would.
  task automatic wait_pulse(output int n, input int budget);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(dem_done | pf_done | pf_drop) && n < budget);
    if (!(dem_done | pf_done | pf_drop)) begin
      checks++;
      errors++;
      $display("FAIL pulse_timeout actual=no pulse in %0d cycles required=pulse", budget);
      n = -1;
    end
    if (dem_done) dem_req = 1'b0;
    if (pf_done || pf_drop) pf_req = 1'b0;
  endtask

  initial begin : main
    int n;
    int pulses;
    checks = 0; errors = 0;
    rst_n = 1'b0; dem_req = 1'b0; pf_req = 1'b0; never_ready = 1'b0;
    dem_addr = '0; pf_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_ren", BW'(mem_if.mem_ren), BW'(0));
    chk("rst_addr", BW'(mem_if.mem_addr), BW'(0));
    chk("rst_pulses", BW'({dem_done, pf_done, pf_drop}), BW'(0));
    chk("rst_rdata", rdata, BW'(0));
    chk("rst_err", BW'(err), BW'(0));
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single demand read of block 0x05.
    evq.push_back(mk(1'b1, 1'b0, 1'b0, 10'h005, blk(10'h005), 1'b0, 3));
    dem_addr = 10'h005; dem_req = 1'b1;
    wait_pulse(n, 20);
    chk("t1_latency", BW'(n), BW'(4));
    chk("t1_kind", BW'({dem_done, pf_done, pf_drop}), BW'(3'b100));
    chk("t1_rdata", rdata, 128'h5405_5405_5405_5405_5405_5405_5405_5405);
    repeat (3) @(negedge clk);

    // Simultaneous demand and prefetch: demand first, prefetch after gap + idle.
    evq.push_back(mk(1'b1, 1'b0, 1'b0, 10'h010, blk(10'h010), 1'b0, 3));
    evq.push_back(mk(1'b0, 1'b1, 1'b0, 10'h020, blk(10'h020), 1'b0, 3));
    dem_addr = 10'h010; dem_req = 1'b1;
    pf_addr  = 10'h020; pf_req  = 1'b1;
    wait_pulse(n, 20);
    chk("t2_dem_latency", BW'(n), BW'(4));
    chk("t2_dem_kind", BW'({dem_done, pf_done, pf_drop}), BW'(3'b100));
    chk("t2_dem_rdata", rdata, 128'h5410_5410_5410_5410_5410_5410_5410_5410);
    wait_pulse(n, 20);
    chk("t2_pf_spacing", BW'(n), BW'(5));
    chk("t2_pf_kind", BW'({dem_done, pf_done, pf_drop}), BW'(3'b010));
    chk("t2_pf_rdata", rdata, 128'h5420_5420_5420_5420_5420_5420_5420_5420);
    repeat (3) @(negedge clk);

    // Demand to a different block pre-empts an in-flight prefetch.
    evq.push_back(mk(1'b0, 1'b0, 1'b1, 10'h020, '0, 1'b0, 1));
    pf_addr = 10'h020; pf_req = 1'b1;
    @(negedge clk);
    chk("t3_ren_up", BW'(mem_if.mem_ren), BW'(1));
    evq.push_back(mk(1'b1, 1'b0, 1'b0, 10'h030, blk(10'h030), 1'b0, 3));
    dem_addr = 10'h030; dem_req = 1'b1;
    wait_pulse(n, 20);
    chk("t3_drop_latency", BW'(n), BW'(1));
    chk("t3_drop_kind", BW'({dem_done, pf_done, pf_drop}), BW'(3'b001));
    wait_pulse(n, 20);
    chk("t3_dem_spacing", BW'(n), BW'(5));
    chk("t3_dem_kind", BW'({dem_done, pf_done, pf_drop}), BW'(3'b100));
    chk("t3_rdata", rdata, 128'h5430_5430_5430_5430_5430_5430_5430_5430);
    repeat (3) @(negedge clk);

    // Demand to the block already being prefetched joins that read.
    evq.push_back(mk(1'b1, 1'b1, 1'b0, 10'h040, blk(10'h040), 1'b0, 3));
    pf_addr = 10'h040; pf_req = 1'b1;
    @(negedge clk);
    dem_addr = 10'h040; dem_req = 1'b1;
    wait_pulse(n, 20);
    chk("t4_latency", BW'(n), BW'(3));
    chk("t4_kind", BW'({dem_done, pf_done, pf_drop}), BW'(3'b110));
    chk("t4_rdata", rdata, 128'h5440_5440_5440_5440_5440_5440_5440_5440);
    repeat (3) @(negedge clk);

    // Both requesters on the same block in the same idle cycle.
    evq.push_back(mk(1'b1, 1'b1, 1'b0, 10'h050, blk(10'h050), 1'b0, 3));
    dem_addr = 10'h050; dem_req = 1'b1;
    pf_addr  = 10'h050; pf_req  = 1'b1;
    wait_pulse(n, 20);
    chk("t4b_kind", BW'({dem_done, pf_done, pf_drop}), BW'(3'b110));
    repeat (3) @(negedge clk);

    // Memory never answers: timeout after TMO read cycles, sticky err.
    never_ready = 1'b1;
    evq.push_back(mk(1'b1, 1'b0, 1'b0, 10'h055, '0, 1'b1, TMO));
    dem_addr = 10'h055; dem_req = 1'b1;
    wait_pulse(n, 40);
    chk("t5_latency", BW'(n), BW'(9));
    chk("t5_kind", BW'({dem_done, pf_done, pf_drop}), BW'(3'b100));
    chk("t5_err", BW'(err), BW'(1));
    chk("t5_rdata", rdata, BW'(0));
    never_ready = 1'b0;
    repeat (3) @(negedge clk);
    evq.push_back(mk(1'b1, 1'b0, 1'b0, 10'h066, blk(10'h066), 1'b0, 3));
    dem_addr = 10'h066; dem_req = 1'b1;
    wait_pulse(n, 20);
    chk("t5_next_latency", BW'(n), BW'(4));
    chk("t5_err_sticky", BW'(err), BW'(1));
    chk("t5_next_rdata", rdata, 128'h5466_5466_5466_5466_5466_5466_5466_5466);
    repeat (3) @(negedge clk);

    // Reset in the middle of a read.
    evq.push_back(mk(1'b1, 1'b0, 1'b0, 10'h077, blk(10'h077), 1'b0, 3));
    dem_addr = 10'h077; dem_req = 1'b1;
    @(negedge clk);
    chk("t6_ren_up", BW'(mem_if.mem_ren), BW'(1));
    @(negedge clk);
    #2 rst_n = 1'b0;
    dem_req = 1'b0;
    #1;
    chk("t6_ren_async", BW'(mem_if.mem_ren), BW'(0));
    chk("t6_addr", BW'(mem_if.mem_addr), BW'(0));
    chk("t6_pulses_err", BW'({dem_done, pf_done, pf_drop, err}), BW'(0));
    chk("t6_rdata", rdata, BW'(0));
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    pulses = 0;
    repeat (10) begin
      @(negedge clk);
      if (dem_done | pf_done | pf_drop) pulses++;
    end
    chk("t6_no_spurious", BW'(pulses), BW'(0));
    evq.push_back(mk(1'b1, 1'b0, 1'b0, 10'h005, blk(10'h005), 1'b0, 3));
    dem_addr = 10'h005; dem_req = 1'b1;
    wait_pulse(n, 20);
    chk("t6_after_latency", BW'(n), BW'(4));
    chk("t6_after_err", BW'(err), BW'(0));
    repeat (3) @(negedge clk);

    chk("events_drained", BW'(evq.size()), BW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
